// File: rtl/a1csa_seq_adder.sv
// Sequential block-serial adder: one B-bit block per cycle, each block using an add-one carry-select step.
// Optional overflow output enabled by defining A1CSA_SEQ_ADDER_OVF_EN.
module a1csa_seq_adder #(
  parameter int N = 8,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef A1CSA_SEQ_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int NB = N / B;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_r, b_r, sum_r;
  logic [IW-1:0]  idx;
  logic           carry, cout_r;
  logic [B-1:0]   a_blk, b_blk, rs;
  logic [B:0]     s;
  logic           bco, last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The block sum is formed without carry-in; the registered carry then selects s or s+1.
  always_comb begin
    a_blk = a_r[idx*B +: B];
    b_blk = b_r[idx*B +: B];
    s     = {1'b0, a_blk} + {1'b0, b_blk};
    rs    = s[B-1:0] + {{(B-1){1'b0}}, carry};
    bco   = s[B] | (carry & (&s[B-1:0]));
    last  = (idx == IW'(NB - 1));
  end

`ifdef A1CSA_SEQ_ADDER_OVF_EN
  logic ovf_r;
  always_ff @(posedge clk) begin
    if (rst) ovf_r <= 1'b0;
    else if (state_q == RUN && last)
      ovf_r <= (rs[B-1] ^ a_blk[B-1] ^ b_blk[B-1]) ^ bco;
  end
  assign ovf = ovf_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          idx   <= '0;
          carry <= cin;
        end
        RUN: begin
          sum_r[idx*B +: B] <= rs;
          carry             <= bco;
          if (last) cout_r <= bco;
          else      idx    <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_a1csa_seq_adder.sv
// Self-checking bench for a1csa_seq_adder (N=8, B=4): directed table, stall/reset sequences, swept back-to-back run.
module tb_a1csa_seq_adder;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [7:0] a, b, sum;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  a1csa_seq_adder #(.N(8), .B(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef A1CSA_SEQ_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

`ifndef A1CSA_SEQ_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       ec;
    logic       eo;
    int         stall;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 1);
    a = v.va; b = v.vb; cin = v.vc; in_valid = 1'b1;
    out_ready = (v.stall == 0);
    @(negedge clk);
    in_valid = 1'b0; a = ~v.va; b = ~v.vb; cin = ~v.vc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 2);
    check("sum", {24'd0, sum}, {24'd0, v.es});
    check("cout", {31'd0, cout}, {31'd0, v.ec});
`ifdef A1CSA_SEQ_ADDER_OVF_EN
    check("ovf", {31'd0, ovf}, {31'd0, v.eo});
`endif
    for (int s = 0; s < v.stall; s++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_ready", {31'd0, in_ready}, 0);
      check("stall_sum", {24'd0, sum}, {24'd0, v.es});
      check("stall_cout", {31'd0, cout}, {31'd0, v.ec});
`ifdef A1CSA_SEQ_ADDER_OVF_EN
      check("stall_ovf", {31'd0, ovf}, {31'd0, v.eo});
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'd0, out_valid}, 0);
    check("post_ready", {31'd0, in_ready}, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    vecs[6] = '{8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1, 3};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h5A; b = 8'hA5; cin = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Leave a nonzero result in place, then abort a fresh operation one cycle after acceptance.
    run_txn('{8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1, 0});
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 1);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout", {31'd0, cout}, 0);
    check("abort_ovf", {31'd0, ovf}, 0);
    begin
      int seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
    end

    // Back-to-back sweep: all a, b in steps of 0x11, both cin values.
    begin
      logic [8:0] expq[$];
      logic [7:0] opa[$];
      logic [7:0] opb[$];
      logic [7:0] sa, sb;
      logic       sc;
      int         issued = 0, retired = 0, total = 256 * 16 * 2, cyc = 0;
      out_ready = 1'b1;
      while (retired < total && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        in_valid = 1'b0;
        if (out_valid) begin
          logic [8:0] e;
          logic [7:0] qa, qb;
          e = expq.pop_front(); qa = opa.pop_front(); qb = opb.pop_front();
          check("sweep_sum", {24'd0, sum}, {24'd0, e[7:0]});
          check("sweep_cout", {31'd0, cout}, {31'd0, e[8]});
`ifdef A1CSA_SEQ_ADDER_OVF_EN
          check("sweep_ovf", {31'd0, ovf},
                {31'd0, (qa[7] == qb[7]) && (e[7] != qa[7])});
`endif
          retired++;
        end else if (in_ready && issued < total) begin
          sa = 8'(issued / 32);
          sb = 8'(((issued / 2) % 16) * 17);
          sc = 1'(issued % 2);
          a = sa; b = sb; cin = sc; in_valid = 1'b1;
          expq.push_back({1'b0, sa} + {1'b0, sb} + {8'd0, sc});
          opa.push_back(sa);
          opb.push_back(sb);
          issued++;
        end
      end
      in_valid = 1'b0;
      check("sweep_done", retired, total);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
